// File: rtl/voice_allocator.sv
// Voice allocator: turns note-on/note-off events into a per-voice enable mask
// and note numbers. A free voice is allocated first, a repeated note retriggers,
// and when every voice is busy the oldest one is stolen. Each event is resolved
// by scanning the voices one per cycle, then committed in a single APPLY cycle.
module voice_allocator #(
  parameter int NUM_VOICES = 12,
  parameter int NOTE_W     = 7,
  parameter int AGE_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ev_valid,
  output logic                  ev_ready,
  input  logic                  ev_on,
  input  logic [NOTE_W-1:0]     ev_note,
  input  logic                  all_off,
  output logic [NUM_VOICES-1:0] voice_enable,
  output logic [NOTE_W-1:0]     voice_note [NUM_VOICES-1:0],
  output logic [NUM_VOICES-1:0] voice_start,
  output logic                  steal
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  on_q, on_d;
  logic [NOTE_W-1:0]     evnote_q, evnote_d;
  logic                  match_vld_q, match_vld_d;
  logic [IDX_W-1:0]      match_idx_q, match_idx_d;
  logic                  free_vld_q, free_vld_d;
  logic [IDX_W-1:0]      free_idx_q, free_idx_d;
  logic                  old_vld_q, old_vld_d;
  logic [IDX_W-1:0]      old_idx_q, old_idx_d;
  logic [AGE_W-1:0]      old_age_q, old_age_d;
  logic [NUM_VOICES-1:0] en_q, en_d;
  logic [NUM_VOICES-1:0] start_q, start_d;
  logic                  steal_q, steal_d;
  logic [NOTE_W-1:0]     note_q [NUM_VOICES-1:0];
  logic [NOTE_W-1:0]     note_d [NUM_VOICES-1:0];
  logic [AGE_W-1:0]      age_q [NUM_VOICES-1:0];
  logic [AGE_W-1:0]      age_d [NUM_VOICES-1:0];
  logic [IDX_W-1:0]      tgt;
  logic                  hs;

  // Ages stick at the maximum so a long-held voice never wraps to look young.
  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
    return (a == {AGE_W{1'b1}}) ? a : a + 1'b1;
  endfunction

  assign ev_ready     = (state_q == IDLE) && !all_off && !rst;
  assign hs           = ev_valid && ev_ready;
  assign voice_enable = en_q;
  assign voice_note   = note_q;
  assign voice_start  = start_q;
  assign steal        = steal_q;

  // FSM next state; panic returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = SCAN;
      SCAN:    if (idx_q == LAST_IDX) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (all_off) state_d = IDLE;
  end

  // Event latch, per-voice scan, and commit of the scan result.
  always_comb begin
    idx_d       = idx_q;
    on_d        = on_q;
    evnote_d    = evnote_q;
    match_vld_d = match_vld_q;
    match_idx_d = match_idx_q;
    free_vld_d  = free_vld_q;
    free_idx_d  = free_idx_q;
    old_vld_d   = old_vld_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
    en_d        = en_q;
    note_d      = note_q;
    age_d       = age_q;
    start_d     = '0;
    steal_d     = 1'b0;
    tgt         = '0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          on_d        = ev_on;
          evnote_d    = ev_note;
          idx_d       = '0;
          match_vld_d = 1'b0;
          free_vld_d  = 1'b0;
          old_vld_d   = 1'b0;
          old_age_d   = '0;
        end
      end
      SCAN: begin
        if (en_q[idx_q]) begin
          if (!match_vld_q && note_q[idx_q] == evnote_q) begin
            match_vld_d = 1'b1;
            match_idx_d = idx_q;
          end
          // Strict compare keeps the lowest index on equal ages.
          if (!old_vld_q || age_q[idx_q] > old_age_q) begin
            old_vld_d = 1'b1;
            old_idx_d = idx_q;
            old_age_d = age_q[idx_q];
          end
        end else if (!free_vld_q) begin
          free_vld_d = 1'b1;
          free_idx_d = idx_q;
        end
        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
      APPLY: begin
        if (on_q) begin
          // With no free voice every slot is active, so an oldest always exists.
          tgt = match_vld_q ? match_idx_q : (free_vld_q ? free_idx_q : old_idx_q);
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (en_q[i] && IDX_W'(i) != tgt) age_d[i] = age_inc(age_q[i]);
          end
          en_d[tgt]    = 1'b1;
          note_d[tgt]  = evnote_q;
          age_d[tgt]   = '0;
          start_d[tgt] = 1'b1;
          steal_d      = !match_vld_q && !free_vld_q;
        end else if (match_vld_q) begin
          en_d[match_idx_q] = 1'b0;
        end
      end
      default: ;
    endcase
    if (all_off) begin
      en_d    = '0;
      start_d = '0;
      steal_d = 1'b0;
      idx_d   = '0;
      for (int i = 0; i < NUM_VOICES; i++) age_d[i] = '0;
    end
  end

  // State and voice registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      on_q        <= 1'b0;
      evnote_q    <= '0;
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
      old_vld_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
      en_q        <= '0;
      start_q     <= '0;
      steal_q     <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      on_q        <= on_d;
      evnote_q    <= evnote_d;
      match_vld_q <= match_vld_d;
      match_idx_q <= match_idx_d;
      free_vld_q  <= free_vld_d;
      free_idx_q  <= free_idx_d;
      old_vld_q   <= old_vld_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
      en_q        <= en_d;
      start_q     <= start_d;
      steal_q     <= steal_d;
      note_q      <= note_d;
      age_q       <= age_d;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation, release/refill, stealing,
// retrigger, panic and reset behaviour with hand-computed expected values.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic        ev_on = 1'b0;
  logic [6:0]  ev_note = '0;
  logic        all_off = 1'b0;
  logic [11:0] voice_enable;
  logic [6:0]  voice_note [11:0];
  logic [11:0] voice_start;
  logic        steal;

  int total  = 0;
  int passed = 0;

  voice_allocator dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .all_off(all_off),
    .voice_enable(voice_enable), .voice_note(voice_note),
    .voice_start(voice_start), .steal(steal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for ev_ready, then present the event for one handshake edge.
  task automatic hs_ev(input logic on, input logic [6:0] n);
    int k;
    @(negedge clk);
    k = 0;
    while (!ev_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("ev_ready_wait", {31'd0, ev_ready}, 32'd1);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_note  = n;
    @(posedge clk);
    #1 ev_valid = 1'b0;
  endtask

  // Full event: returns at the negedge of cycle T+14 where results appear.
  task automatic send(input logic on, input logic [6:0] n);
    hs_ev(on, n);
    repeat (13) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rdy_in_rst", {31'd0, ev_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_en", {20'd0, voice_enable}, 32'h000);
    chk("rst_start", {20'd0, voice_start}, 32'h000);
    chk("rst_steal", {31'd0, steal}, 32'd0);
    chk("rst_note0", {25'd0, voice_note[0]}, 32'd0);
    chk("rst_rdy", {31'd0, ev_ready}, 32'd1);

    // 1: single note-on, latency and pulse width
    send(1'b1, 7'd60);
    chk("t1_en", {20'd0, voice_enable}, 32'h001);
    chk("t1_note0", {25'd0, voice_note[0]}, 32'd60);
    chk("t1_start", {20'd0, voice_start}, 32'h001);
    chk("t1_rdy", {31'd0, ev_ready}, 32'd1);
    @(negedge clk);
    chk("t1_start_gone", {20'd0, voice_start}, 32'h000);

    // 2: release and refill of the lowest free voice
    do_reset();
    send(1'b1, 7'd60);
    send(1'b1, 7'd62);
    send(1'b1, 7'd64);
    chk("t2_en3", {20'd0, voice_enable}, 32'h007);
    chk("t2_start3", {20'd0, voice_start}, 32'h004);
    send(1'b0, 7'd62);
    chk("t2_en_off", {20'd0, voice_enable}, 32'h005);
    chk("t2_off_nostart", {20'd0, voice_start}, 32'h000);
    chk("t2_note1_kept", {25'd0, voice_note[1]}, 32'd62);
    send(1'b1, 7'd67);
    chk("t2_en_refill", {20'd0, voice_enable}, 32'h007);
    chk("t2_note1", {25'd0, voice_note[1]}, 32'd67);
    chk("t2_start_refill", {20'd0, voice_start}, 32'h002);

    // 3: fill all voices, then steal oldest twice
    do_reset();
    for (int i = 0; i < 12; i++) send(1'b1, 7'(40 + i));
    chk("t3_full", {20'd0, voice_enable}, 32'hFFF);
    chk("t3_note11", {25'd0, voice_note[11]}, 32'd51);
    chk("t3_nosteal", {31'd0, steal}, 32'd0);
    send(1'b1, 7'd70);
    chk("t3_note0", {25'd0, voice_note[0]}, 32'd70);
    chk("t3_steal", {31'd0, steal}, 32'd1);
    chk("t3_start", {20'd0, voice_start}, 32'h001);
    chk("t3_en", {20'd0, voice_enable}, 32'hFFF);
    @(negedge clk);
    chk("t3_steal_gone", {31'd0, steal}, 32'd0);
    send(1'b1, 7'd71);
    chk("t3_note1", {25'd0, voice_note[1]}, 32'd71);
    chk("t3_start2", {20'd0, voice_start}, 32'h002);
    chk("t3_steal2", {31'd0, steal}, 32'd1);

    // 4: retrigger of a held note
    do_reset();
    send(1'b1, 7'd60);
    send(1'b1, 7'd60);
    chk("t4_en", {20'd0, voice_enable}, 32'h001);
    chk("t4_start", {20'd0, voice_start}, 32'h001);
    chk("t4_steal", {31'd0, steal}, 32'd0);

    // 5: panic blocks the handshake, then aborts an in-flight event
    do_reset();
    send(1'b1, 7'd50);
    chk("t5_en_pre", {20'd0, voice_enable}, 32'h001);
    all_off = 1'b1;
    #1;
    chk("t5_rdy_alloff", {31'd0, ev_ready}, 32'd0);
    all_off = 1'b0;
    hs_ev(1'b1, 7'd72);
    @(negedge clk);
    all_off = 1'b1;
    #1;
    chk("t5_rdy_scan", {31'd0, ev_ready}, 32'd0);
    @(negedge clk);
    all_off = 1'b0;
    #1;
    chk("t5_en_cleared", {20'd0, voice_enable}, 32'h000);
    chk("t5_start", {20'd0, voice_start}, 32'h000);
    chk("t5_rdy_back", {31'd0, ev_ready}, 32'd1);
    repeat (14) @(negedge clk);
    chk("t5_dropped_en", {20'd0, voice_enable}, 32'h000);
    chk("t5_dropped_start", {20'd0, voice_start}, 32'h000);
    send(1'b1, 7'd72);
    chk("t5_after_en", {20'd0, voice_enable}, 32'h001);
    chk("t5_after_note0", {25'd0, voice_note[0]}, 32'd72);

    // 6: note-off with no match, then reset during SCAN
    do_reset();
    send(1'b1, 7'd10);
    send(1'b0, 7'd99);
    chk("t6_en", {20'd0, voice_enable}, 32'h001);
    chk("t6_note0", {25'd0, voice_note[0]}, 32'd10);
    chk("t6_start", {20'd0, voice_start}, 32'h000);
    chk("t6_steal", {31'd0, steal}, 32'd0);
    hs_ev(1'b1, 7'd20);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rdy_rst", {31'd0, ev_ready}, 32'd0);
    @(negedge clk);
    chk("t6_rst_en", {20'd0, voice_enable}, 32'h000);
    chk("t6_rst_note0", {25'd0, voice_note[0]}, 32'd0);
    chk("t6_rst_start", {20'd0, voice_start}, 32'h000);
    chk("t6_rst_steal", {31'd0, steal}, 32'd0);
    rst = 1'b0;
    #1;
    chk("t6_rdy_after", {31'd0, ev_ready}, 32'd1);
    repeat (14) @(negedge clk);
    chk("t6_no_commit", {20'd0, voice_enable}, 32'h000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
